l1a_bxn_stamp: RTL
==================

# l1a_bxn_stamp

Upstream feeder for `l1a_bxn_fifo`.
- Maintains the LHC bunch-crossing counter, which is resynchronised by BC0.
- On each L1A, captures the current BXN and subtracts the programmed L1A latency modulo the orbit length.
- Writes the corrected 12-bit stamp into the FIFO (`fifo_din`/`fifo_wen`), honouring `fifo_full`.
- Keeps L1A, lost-L1A and orbit-error bookkeeping for slow control.

## Interface
Parameters:
- `ORBIT_LEN`, 3564: bunch crossings per orbit; BXN range is 0..ORBIT_LEN-1.
- `L1A_CNT_W`, 24: width of the L1A event counter.
- `LOST_W`, 16: width of the saturating lost-L1A counter.

Ports (one clock `clk`; `reset` is synchronous and active-high):
- `clk`  in  1  system 40 MHz clock
- `reset`  in  1  synchronous, active-high; clears all state
- `bc0`  in  1  bunch-crossing-zero marker, one-cycle pulse
- `bxn_offset`  in  12  value loaded into the BXN counter on `bc0`; must be < ORBIT_LEN
- `l1a`  in  1  level-1 accept, one-cycle pulse; may be asserted on consecutive cycles
- `l1a_lat`  in  12  L1A latency in BX; static, must be < ORBIT_LEN
- `fifo_full`  in  1  full flag from `l1a_bxn_fifo`
- `fifo_din`  out  12  corrected BXN stamp
- `fifo_wen`  out  1  FIFO write strobe, one cycle per accepted stamp
- `bxn`  out  12  current BXN counter value
- `l1a_cnt`  out  L1A_CNT_W  number of L1As received since reset; wraps
- `l1a_lost`  out  LOST_W  number of stamps dropped because of `fifo_full`; saturates at all-ones
- `bc0_seen`  out  1  sticky; set on the first `bc0` after reset
- `bc0_err`  out  1  sticky orbit-mismatch flag

## Operation

BXN counter, every cycle:
- if `bc0`: `bxn` <= `bxn_offset`;
- else if `bxn` == ORBIT_LEN-1: `bxn` <= 0;
- else: `bxn` <= `bxn`+1.

`bc0_err` is set when all of the following hold:
- `bc0`=1 and `bc0_seen`=1 already;
- the natural next value (the wrap/increment result) ≠ `bxn_offset`.

The first `bc0` after reset only sets `bc0_seen` and never raises `bc0_err`.

Stamp pipeline, two stages:
- **S1:** on `l1a`=1, register `raw`=`bxn` (the value present in the L1A cycle), set `v1`=1, and increment `l1a_cnt`.
- **S2:** compute `diff` = `raw` − `l1a_lat` in 13 bits. If `diff` is negative, add ORBIT_LEN. Register the low 12 bits into `fifo_din` with `v2`=`v1`.
- **Write:** `fifo_wen` = `v2` & !`fifo_full`. When `v2` & `fifo_full`, the stamp is dropped and `l1a_lost` increments (saturating). No retry and no back-pressure towards the TTC side.

Other rules:
- Each L1A yields exactly one write or one lost count. Back-to-back L1As produce back-to-back writes.
- `fifo_din` holds its last value when `fifo_wen`=0.
- Illegal `l1a_lat` or `bxn_offset` (≥ ORBIT_LEN): `fifo_din` is undefined, but write and lost accounting still follow the rules above.

## Timing
- Reset values: `bxn`=0, `fifo_din`=0, `fifo_wen`=0, `l1a_cnt`=0, `l1a_lost`=0, `bc0_seen`=0, `bc0_err`=0, `v1`=`v2`=0.
- `reset` has priority over `bc0` and `l1a` in the same cycle; that L1A is neither counted nor stamped.
- Reset mid-pipeline discards any in-flight stamps.
- Latency: `l1a` in cycle N gives `fifo_wen` in cycle N+2. `l1a_cnt` updates visibly in N+1.
- `fifo_full` is sampled combinationally in cycle N+2. Since the FIFO's `full` is registered, at most one stamp per full-transition can be presented against a stale flag; this is accepted.
- `bc0` in cycle N gives `bxn`=`bxn_offset` in N+1. An `l1a` in cycle N stamps the pre-`bc0` value.
- Orbit wrap: `bxn`=3563 at N gives 0 at N+1.

## Structure
- Shared package `alct_ttc_pkg` holds:
  - `BXN_W` = 12;
  - `ORBIT_LEN` = 3564;
  - function `bxn_sub(a, b)` for the modular subtraction, which is reused by the readout header logic.
- One sub-module, `bxn_counter`, contains the counter, `bc0_seen` and `bc0_err`.
- The top level contains the stamp pipeline and the L1A/lost counters.

## Test plan
- **Wrap and resync:** reset, then run 3565 cycles. `bxn` goes 0..3563 then 0. Apply `bc0` with `bxn_offset`=5 at `bxn`=100: `bxn`=5 next cycle, `bc0_seen`=1, `bc0_err`=0.
- **Orbit error:** after the first `bc0`, run exactly one orbit and apply `bc0` with `bxn_offset`=5 when the natural next value is 5: no error. Repeat one cycle early: `bc0_err`=1 and stays set until reset.
- **Latency subtraction:** `l1a_lat`=10 and `l1a` at `bxn`=100 give `fifo_din`=90 with `fifo_wen` two cycles later. `l1a` at `bxn`=3 gives `fifo_din`=3557.
- **Back-to-back L1As:** 4 consecutive `l1a` pulses at `bxn`=200..203 with `l1a_lat`=0 give 4 consecutive writes 200..203. `l1a_cnt`=4.
- **Full FIFO:** hold `fifo_full`=1 and issue 3 L1As: `fifo_wen` stays 0, `l1a_lost`=3, `l1a_cnt`=3. Preset `l1a_lost` to all-ones-1 and issue 3 more: it saturates at all-ones.
- **Reset mid-flight:** `l1a` in cycle N and `reset` in N+1: no `fifo_wen` in N+2, and all outputs are at their reset values.

Source files
------------

// File: rtl/alct_ttc_pkg.sv
// Shared TTC definitions: BXN width, LHC orbit length and the modular
// BXN subtraction used by both the L1A stamper and the readout header logic.
package alct_ttc_pkg;

   localparam int BXN_W     = 12;
   localparam int ORBIT_LEN = 3564;

   // (a - b) modulo orbit, computed in BXN_W+1 bits so a borrow shows up as
   // the sign bit; a negative difference is folded back by adding the orbit.
   function automatic logic [BXN_W-1:0] bxn_sub(
      input logic [BXN_W-1:0] a,
      input logic [BXN_W-1:0] b,
      input int unsigned      orbit = ORBIT_LEN
   );
      logic [BXN_W:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      if (diff[BXN_W]) begin
         diff = diff + orbit[BXN_W:0];
      end
      return diff[BXN_W-1:0];
   endfunction

endpackage

// File: rtl/bxn_counter.sv
// Bunch-crossing counter with BC0 resynchronisation, plus the sticky
// "first BC0 seen" and "orbit length mismatch" flags.
module bxn_counter
   import alct_ttc_pkg::BXN_W;
#(
   parameter int ORBIT_LEN = alct_ttc_pkg::ORBIT_LEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bc0,
   input  logic [BXN_W-1:0] bxn_offset,
   output logic [BXN_W-1:0] bxn,
   output logic             bc0_seen,
   output logic             bc0_err
);

   logic [BXN_W-1:0] bxn_reg;
   logic [BXN_W-1:0] bxn_natural;
   logic             bc0_seen_reg;
   logic             bc0_err_reg;

   // Value the counter would take without a BC0: increment with orbit wrap.
   always_comb begin
      bxn_natural = bxn_reg + BXN_W'(1);
      if (bxn_reg == BXN_W'(ORBIT_LEN - 1)) begin
         bxn_natural = '0;
      end
   end

   // Counter and flags; only a BC0 after the first one can flag a mismatch,
   // since before that the counter phase is arbitrary.
   always_ff @(posedge clk) begin
      if (reset) begin
         bxn_reg      <= '0;
         bc0_seen_reg <= 1'b0;
         bc0_err_reg  <= 1'b0;
      end else if (bc0) begin
         bxn_reg      <= bxn_offset;
         bc0_seen_reg <= 1'b1;
         if (bc0_seen_reg && (bxn_natural != bxn_offset)) begin
            bc0_err_reg <= 1'b1;
         end
      end else begin
         bxn_reg <= bxn_natural;
      end
   end

   assign bxn      = bxn_reg;
   assign bc0_seen = bc0_seen_reg;
   assign bc0_err  = bc0_err_reg;

endmodule

// File: rtl/l1a_bxn_stamp.sv
// L1A BXN stamper: captures the BXN on each L1A, removes the trigger
// latency modulo the orbit and writes the stamp into l1a_bxn_fifo,
// dropping (and counting) stamps that meet a full FIFO.
module l1a_bxn_stamp
   import alct_ttc_pkg::BXN_W;
   import alct_ttc_pkg::bxn_sub;
#(
   parameter int ORBIT_LEN = alct_ttc_pkg::ORBIT_LEN,
   parameter int L1A_CNT_W = 24,
   parameter int LOST_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bc0,
   input  logic [BXN_W-1:0]     bxn_offset,
   input  logic                 l1a,
   input  logic [BXN_W-1:0]     l1a_lat,
   input  logic                 fifo_full,
   output logic [BXN_W-1:0]     fifo_din,
   output logic                 fifo_wen,
   output logic [BXN_W-1:0]     bxn,
   output logic [L1A_CNT_W-1:0] l1a_cnt,
   output logic [LOST_W-1:0]    l1a_lost,
   output logic                 bc0_seen,
   output logic                 bc0_err
);

   logic [BXN_W-1:0]     raw_reg;
   logic                 v1_reg;
   logic [BXN_W-1:0]     din_reg;
   logic                 v2_reg;
   logic [BXN_W-1:0]     stamp_next;
   logic [L1A_CNT_W-1:0] l1a_cnt_reg;
   logic [LOST_W-1:0]    lost_reg;
   logic                 drop;

   bxn_counter #(
      .ORBIT_LEN (ORBIT_LEN)
   ) u_bxn_counter (
      .clk        (clk),
      .reset      (reset),
      .bc0        (bc0),
      .bxn_offset (bxn_offset),
      .bxn        (bxn),
      .bc0_seen   (bc0_seen),
      .bc0_err    (bc0_err)
   );

   // Latency-corrected stamp of the captured BXN.
   always_comb begin
      stamp_next = bxn_sub(raw_reg, l1a_lat, ORBIT_LEN);
   end

   // Stage 1: capture the BXN present in the L1A cycle and count the L1A.
   always_ff @(posedge clk) begin
      if (reset) begin
         raw_reg     <= '0;
         v1_reg      <= 1'b0;
         l1a_cnt_reg <= '0;
      end else begin
         v1_reg <= l1a;
         if (l1a) begin
            raw_reg     <= bxn;
            l1a_cnt_reg <= l1a_cnt_reg + L1A_CNT_W'(1);
         end
      end
   end

   // Stage 2: register the corrected stamp; the output holds between stamps.
   always_ff @(posedge clk) begin
      if (reset) begin
         din_reg <= '0;
         v2_reg  <= 1'b0;
      end else begin
         v2_reg <= v1_reg;
         if (v1_reg) begin
            din_reg <= stamp_next;
         end
      end
   end

   // A stamp that meets a full FIFO is dropped; there is no retry path.
   assign drop     = v2_reg & fifo_full;
   assign fifo_wen = v2_reg & ~fifo_full;

   // Saturating count of dropped stamps.
   always_ff @(posedge clk) begin
      if (reset) begin
         lost_reg <= '0;
      end else if (drop && (lost_reg != {LOST_W{1'b1}})) begin
         lost_reg <= lost_reg + LOST_W'(1);
      end
   end

   assign fifo_din = din_reg;
   assign l1a_cnt  = l1a_cnt_reg;
   assign l1a_lost = lost_reg;

endmodule
